// File: rtl/gemips_pipe_pkg.sv
// ----------------------------------------------------------------------------
// gemips_pipe_pkg
// Shared definitions for the GeMIPS pipeline hazard logic:
//   - stage index constants (STG_IF .. STG_WB), index 0 is the youngest stage
//   - default stage count and default stage that owns the data-memory wait
//   - MEM-wait FSM state type
// No ports (package).
// ----------------------------------------------------------------------------
package gemips_pipe_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam int DEF_NSTAGE  = 5;
  localparam int DEF_MEM_IDX = STG_MEM;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mw_state_e;

endpackage

// File: rtl/hzd_prio_enc.sv
// ----------------------------------------------------------------------------
// hzd_prio_enc
// Highest-set-bit encoder. Reports the index of the most significant set bit
// of i_vec (the oldest requesting stage) and whether any bit is set.
// Ports:
//   i_vec    in  N       request vector
//   o_idx    out IW      index of highest set bit (0 when none set)
//   o_valid  out 1       at least one bit of i_vec is set
// ----------------------------------------------------------------------------
module hzd_prio_enc #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  // Scan upward so the last (highest) set bit wins.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      o_idx   = i_vec[i] ? IW'(i) : o_idx;
      o_valid = o_valid | i_vec[i];
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush controller for the GeMIPS pipeline. Merges per-stage
// stall requests, per-stage flush requests (with deferral while the requester
// is itself stalled) and a multi-cycle MEM-wait FSM with timeout into
// per-stage stall/flush vectors. Stall/flush are combinational (0 latency).
// Optional feature: define STALL_CNT_EN to enable the stall-cycle counter;
// otherwise o_stall_cycles is tied to zero.
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_stall_req[N]      stage k cannot advance this cycle
//   i_flush_req[N]      stage j requests flush of stages 0..j-1
//   i_mem_req/i_mem_ack multi-cycle MEM access start pulse / data returned
//   o_stall[N]          hold stage-i register
//   o_flush[N]          load bubble into stage-i register
//   o_busy              MEM-wait FSM not idle
//   o_timeout_err       one-cycle pulse on MEM-wait timeout
//   o_stall_cycles      count of cycles with o_stall[0]=1
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import gemips_pipe_pkg::*;
#(
  parameter int NSTAGE   = DEF_NSTAGE,
  parameter int MEM_IDX  = DEF_MEM_IDX,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NSTAGE-1:0] i_stall_req,
  input  logic [NSTAGE-1:0] i_flush_req,
  input  logic              i_mem_req,
  input  logic              i_mem_ack,
  output logic [NSTAGE-1:0] o_stall,
  output logic [NSTAGE-1:0] o_flush,
  output logic              o_busy,
  output logic              o_timeout_err,
  output logic [CNT_W-1:0]  o_stall_cycles
);

  localparam int IW  = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);
  localparam logic [WCW-1:0] WAIT_SAT  = WCW'(MAX_WAIT);

  mw_state_e         r_state, w_state_nxt;
  logic [WCW-1:0]    r_wait_cnt, w_wait_cnt_nxt;
  logic [NSTAGE-1:0] r_pend_flush, w_pend_flush_nxt;
  logic              w_mem_hold, w_timeout;
  logic [NSTAGE-1:0] w_eff_stall, w_eff_flush;
  logic [NSTAGE-1:0] w_stall, w_flush;
  logic [IW-1:0]     w_k, w_j;
  logic              w_k_vld, w_j_vld;
  logic              w_flush_go, w_flush_defer;

  // MEM-wait FSM next state, wait counter and hold/timeout decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_mem_hold     = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      IDLE: begin
        // A request answered in the same cycle never stalls the pipe.
        w_mem_hold     = i_mem_req & ~i_mem_ack;
        w_state_nxt    = w_mem_hold ? WAIT : IDLE;
        w_wait_cnt_nxt = '0;
      end
      WAIT: begin
        w_mem_hold = ~i_mem_ack;
        if (i_mem_ack) begin
          w_state_nxt    = IDLE;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt >= WAIT_LAST) begin
          // This cycle's increment would reach MAX_WAIT: give up.
          w_state_nxt    = ERR;
          w_wait_cnt_nxt = '0;
        end else begin
          w_state_nxt    = WAIT;
          w_wait_cnt_nxt = (r_wait_cnt == WAIT_SAT) ? r_wait_cnt : r_wait_cnt + 1'b1;
        end
      end
      ERR: begin
        w_timeout      = 1'b1;
        w_state_nxt    = IDLE;
        w_wait_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt    = IDLE;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  assign w_eff_stall = i_stall_req | (NSTAGE'(w_mem_hold) << MEM_IDX);
  assign w_eff_flush = i_flush_req | r_pend_flush;

  hzd_prio_enc #(.N(NSTAGE), .IW(IW)) u_stall_enc (
    .i_vec   (w_eff_stall),
    .o_idx   (w_k),
    .o_valid (w_k_vld)
  );

  hzd_prio_enc #(.N(NSTAGE), .IW(IW)) u_flush_enc (
    .i_vec   (w_eff_flush),
    .o_idx   (w_j),
    .o_valid (w_j_vld)
  );

  // A flush can only be applied when its requester is not held this cycle.
  assign w_flush_go    = w_j_vld & (~w_k_vld | (w_j > w_k));
  assign w_flush_defer = w_j_vld & w_k_vld & (w_j <= w_k);
  assign w_pend_flush_nxt = w_flush_defer ? w_eff_flush : '0;

  // Per-stage stall/flush vectors.
  always_comb begin
    w_stall = '0;
    w_flush = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (w_flush_go) begin
        // Every stalled stage is younger than the flusher, so nothing is
        // held and no bubble is needed above the stall point.
        w_stall[i] = 1'b0;
        w_flush[i] = (i < int'(w_j));
      end else begin
        w_stall[i] = w_k_vld && (i <= int'(w_k));
        w_flush[i] = w_k_vld && (i == int'(w_k) + 1);
      end
    end
    w_flush[MEM_IDX] = w_flush[MEM_IDX] | w_timeout;
  end

  assign o_stall       = i_rst ? '0 : w_stall;
  assign o_flush       = i_rst ? '1 : w_flush;
  assign o_busy        = ~i_rst & (r_state != IDLE);
  assign o_timeout_err = ~i_rst & w_timeout;

  // FSM, wait counter and deferred-flush registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_wait_cnt   <= '0;
      r_pend_flush <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_pend_flush <= w_pend_flush_nxt;
    end
  end

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;

  // Free-running count of cycles in which the fetch stage was held.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cycles <= '0;
    end else begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(w_stall[0]);
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`else
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench: directed scenarios with literal expectations followed
// by randomized traffic, all checked every cycle against a behavioural model.
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int N  = 5;
  localparam int MI = 3;
  localparam int MW = 15;
  localparam int CW = 32;

  logic          clk;
  logic          rst;
  logic [N-1:0]  stall_req, flush_req;
  logic          mem_req, mem_ack;
  logic [N-1:0]  stall, flush;
  logic          busy, timeout_err;
  logic [CW-1:0] stall_cycles;

  pipe_hazard_ctrl #(.NSTAGE(N), .MEM_IDX(MI), .MAX_WAIT(MW), .CNT_W(CW)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_stall_req    (stall_req),
    .i_flush_req    (flush_req),
    .i_mem_req      (mem_req),
    .i_mem_ack      (mem_ack),
    .o_stall        (stall),
    .o_flush        (flush),
    .o_busy         (busy),
    .o_timeout_err  (timeout_err),
    .o_stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state: phase 0 = idle, 1 = waiting for memory, 2 = timed out
  int            m_phase  = 0;
  int            m_waited = 0;
  int            m_pend   = -1;   // highest pending deferred flush index
  logic [CW-1:0] m_cnt    = '0;
  bit            m_init   = 1'b0;

  // outputs sampled in the most recent cycle
  logic [N-1:0]  a_stall, a_flush;
  logic          a_busy, a_to;
  logic [CW-1:0] a_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check every output against the model,
  // then advance the model across the clock edge.
  task automatic cycle(input logic [N-1:0] sr, input logic [N-1:0] fr,
                       input logic mr, input logic ma, input logic rs);
    logic [N-1:0] e_stall, e_flush;
    logic         e_busy, e_to;
    bit           hold, apply;
    int           k, j;
    @(posedge clk);
    #1;
    stall_req = sr; flush_req = fr; mem_req = mr; mem_ack = ma; rst = rs;
    @(negedge clk);
    e_stall = '0; e_flush = '0; e_busy = 1'b0; e_to = 1'b0;
    k = -1; j = -1; apply = 1'b0;
    if (rs) begin
      e_flush = '1;
    end else begin
      hold = (m_phase == 0 && mr && !ma) || (m_phase == 1 && !ma);
      for (int i = 0; i < N; i++) if (sr[i] || (hold && i == MI)) k = i;
      j = m_pend;
      for (int i = 0; i < N; i++) if (fr[i] && i > j) j = i;
      apply = (j >= 0) && (k < 0 || j > k);
      if (apply) begin
        e_flush = N'((1 << j) - 1);
      end else if (k >= 0) begin
        e_stall = N'((1 << (k + 1)) - 1);
        if (k + 1 < N) e_flush = N'(1 << (k + 1));
      end
      e_busy = (m_phase != 0);
      e_to   = (m_phase == 2);
      if (e_to) e_flush[MI] = 1'b1;
    end
    a_stall = stall; a_flush = flush; a_busy = busy; a_to = timeout_err; a_cnt = stall_cycles;
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("timeout_err", 32'(timeout_err), 32'(e_to));
    if (m_init) begin
`ifdef STALL_CNT_EN
      chk("stall_cycles", stall_cycles, m_cnt);
`else
      chk("stall_cycles", stall_cycles, 32'd0);
`endif
    end
    // advance model
    if (rs) begin
      m_phase = 0; m_waited = 0; m_pend = -1; m_cnt = '0; m_init = 1'b1;
    end else begin
      m_cnt  = m_cnt + CW'(e_stall[0]);
      m_pend = (j >= 0 && !apply) ? j : -1;
      case (m_phase)
        0: if (mr && !ma) begin m_phase = 1; m_waited = 0; end
        1: begin
          if (ma) m_phase = 0;
          else begin
            m_waited++;
            if (m_waited == MW) m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic idle();
    cycle('0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int ack_div;
    stall_req = '0; flush_req = '0; mem_req = 1'b0; mem_ack = 1'b0; rst = 1'b1;

    // reset state
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_stall", 32'(a_stall), 32'h00);
    chk("rst_flush", 32'(a_flush), 32'h1f);
    chk("rst_busy", 32'(a_busy), 32'h0);
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("idle_stall", 32'(a_stall), 32'h00);

    // 1: ID load-use
    cycle(5'b00100, '0, 1'b0, 1'b0, 1'b0);
    chk("t1_stall", 32'(a_stall), 32'h07);
    chk("t1_flush", 32'(a_flush), 32'h08);

    // 2: MEM wait, ack at t4
    cycle('0, '0, 1'b1, 1'b0, 1'b0);
    chk("t2_t0_stall", 32'(a_stall), 32'h0f);
    chk("t2_t0_busy", 32'(a_busy), 32'h0);
    for (int t = 1; t <= 3; t++) begin
      idle();
      chk("t2_wait_stall", 32'(a_stall), 32'h0f);
      chk("t2_wait_busy", 32'(a_busy), 32'h1);
    end
    cycle('0, '0, 1'b0, 1'b1, 1'b0);
    chk("t2_ack_stall", 32'(a_stall), 32'h00);
    idle();
    chk("t2_after_busy", 32'(a_busy), 32'h0);

    // 3: timeout
    cycle('0, '0, 1'b1, 1'b0, 1'b0);
    for (int t = 1; t <= 15; t++) begin
      idle();
      chk("t3_wait_to", 32'(a_to), 32'h0);
    end
    idle();
    chk("t3_to", 32'(a_to), 32'h1);
    chk("t3_flush", 32'(a_flush), 32'h08);
    chk("t3_stall", 32'(a_stall), 32'h00);
    idle();
    chk("t3_busy_after", 32'(a_busy), 32'h0);
    chk("t3_to_after", 32'(a_to), 32'h0);

    // 4: deferred flush released on ack
    cycle('0, '0, 1'b1, 1'b0, 1'b0);
    cycle('0, 5'b00100, 1'b0, 1'b0, 1'b0);
    chk("t4_defer_flush_lo", 32'(a_flush[3:0]), 32'h0);
    idle();
    chk("t4_still_deferred", 32'(a_flush[3:0]), 32'h0);
    cycle('0, '0, 1'b0, 1'b1, 1'b0);
    chk("t4_ack_flush", 32'(a_flush), 32'h03);
    idle();
    chk("t4_cleared", 32'(a_flush), 32'h00);

    // 5: flush overrides stall
    cycle(5'b00010, 5'b00100, 1'b0, 1'b0, 1'b0);
    chk("t5_stall", 32'(a_stall), 32'h00);
    chk("t5_flush", 32'(a_flush), 32'h03);

    // 6: reset while waiting
    cycle('0, '0, 1'b1, 1'b0, 1'b0);
    idle();
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("t6_busy", 32'(a_busy), 32'h0);
    chk("t6_stall", 32'(a_stall), 32'h00);
    chk("t6_to", 32'(a_to), 32'h0);
    chk("t6_cnt", a_cnt, 32'h0);

    // randomized traffic in segments with differing ack latency
    for (int seg = 0; seg < 8; seg++) begin
      ack_div = (seg % 2 == 0) ? 4 : 25;
      for (int c = 0; c < 300; c++) begin
        logic [N-1:0] sr, fr;
        logic mr, ma, rs;
        sr = '0; fr = '0;
        for (int b = 0; b < N; b++) begin
          sr[b] = ($urandom_range(0, 7) == 0);
          fr[b] = ($urandom_range(0, 9) == 0);
        end
        mr = (m_phase == 0) && ($urandom_range(0, 5) == 0);
        ma = ($urandom_range(0, ack_div - 1) == 0);
        rs = ($urandom_range(0, 199) == 0);
        cycle(sr, fr, mr, ma, rs);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
